// File: rtl/flash_arb_pkg.sv
// Shared types and widths for the two-port QSPI flash request arbiter.
package flash_arb_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Command payload presented to the LLC while an operation is in flight
  typedef struct packed {
    logic              dir;
    logic              erase;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
  } llc_cmd_t;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin pick; the requester not served last wins a tie.
module flash_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic owner,
  output logic any_c,
  output logic pick_c
);

  logic last_q;

  // Last-served requester; starts at r1 so r0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= owner;
    end
  end

  // Pick: single requester wins outright, a tie goes away from last_q
  always_comb begin
    any_c  = req0 | req1;
    pick_c = (req0 & req1) ? ~last_q : req1;
  end

endmodule

// File: rtl/flash_req_arbiter.sv
// Shares one QSPI flash LLC between a fetch port (r0) and a data port (r1),
// one command at a time, with prescaled completion polling and a timeout.
module flash_req_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned PRESCALE    = 5,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_rvalid,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic [1:0]        r1_op,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic              llc_start,
  output logic              llc_dir,
  output logic              llc_erase,
  output logic [ADDR_W-1:0] llc_address,
  output logic [DATA_W-1:0] llc_word,
  output logic              llc_axisync,
  input  logic [DATA_W-1:0] llc_rword,
  input  logic              llc_valid,
  input  logic              llc_busy
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESCALE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [TO_W-1:0]   to_q, to_d;
  llc_cmd_t          cmd_q, cmd_d;
  logic              start_d, axisync_d;
  logic [DATA_W-1:0] r0_rdata_d, r1_rdata_d;
  logic              r0_rvalid_d, r0_err_d, r1_done_d, r1_err_d;

  logic              any_c, pick_c;
  logic              grant_c, rsvd_c, sample_c, hit_c, expire_c;
  op_e               req_op_c;

  flash_arb_rr u_rr (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .req0   (r0_req),
    .req1   (r1_req),
    .update (state_q == ST_DONE),
    .owner  (owner_q),
    .any_c  (any_c),
    .pick_c (pick_c)
  );

  // Grant is combinational so the requester sees it in the IDLE cycle itself
  assign grant_c  = (state_q == ST_IDLE) && !llc_busy && any_c;
  assign req_op_c = pick_c ? op_e'(r1_op) : OP_READ;
  assign rsvd_c   = (req_op_c == OP_RSVD);
  assign sample_c = (state_q == ST_WAIT) && (pre_q == '0);
  assign hit_c    = sample_c && llc_valid;
  assign expire_c = (state_q == ST_WAIT) && (to_q == TO_LAST);
  assign r0_gnt   = grant_c && !pick_c;
  assign r1_gnt   = grant_c && pick_c;

  assign llc_dir     = cmd_q.dir;
  assign llc_erase   = cmd_q.erase;
  assign llc_address = cmd_q.addr;
  assign llc_word    = cmd_q.word;

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a sampled llc_valid beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_c) state_d = rsvd_c ? ST_DONE : ST_WAIT;
      ST_WAIT: if (hit_c || expire_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; completion pulses are set on entry to DONE
  always_comb begin
    owner_d    = owner_q;
    rd_d       = rd_q;
    err_d      = err_q;
    pre_d      = pre_q;
    to_d       = to_q;
    cmd_d      = cmd_q;
    start_d    = llc_start;
    r0_rdata_d = r0_rdata;
    r1_rdata_d = r1_rdata;
    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          owner_d = pick_c;
          rd_d    = (req_op_c == OP_READ);
          err_d   = rsvd_c;
          pre_d   = PRE_LOAD;
          to_d    = '0;
          if (!rsvd_c) begin
            start_d     = 1'b1;
            cmd_d.dir   = (req_op_c == OP_WRITE);
            cmd_d.erase = (req_op_c == OP_ERASE);
            cmd_d.addr  = pick_c ? r1_addr : r0_addr;
            cmd_d.word  = pick_c ? r1_wdata : '0;
          end
        end
      end
      ST_WAIT: begin
        to_d  = to_q + 1'b1;
        pre_d = sample_c ? PRE_LOAD : pre_q - 1'b1;
        if (hit_c || expire_c) begin
          start_d = 1'b0;
          cmd_d   = '0;
          err_d   = !hit_c;
          if (hit_c && rd_q) begin
            if (owner_q) r1_rdata_d = llc_rword;
            else         r0_rdata_d = llc_rword;
          end
        end
      end
      default: ;
    endcase
    r0_rvalid_d = (state_d == ST_DONE) && !owner_d;
    r0_err_d    = (state_d == ST_DONE) && !owner_d && err_d;
    r1_done_d   = (state_d == ST_DONE) && owner_d;
    r1_err_d    = (state_d == ST_DONE) && owner_d && err_d;
    axisync_d   = (state_d == ST_IDLE);
  end

  // Registered outputs, command registers and counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      owner_q     <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      pre_q       <= '0;
      to_q        <= '0;
      cmd_q       <= '0;
      llc_start   <= 1'b0;
      llc_axisync <= 1'b1;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      r0_rvalid   <= 1'b0;
      r0_err      <= 1'b0;
      r1_done     <= 1'b0;
      r1_err      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      pre_q       <= pre_d;
      to_q        <= to_d;
      cmd_q       <= cmd_d;
      llc_start   <= start_d;
      llc_axisync <= axisync_d;
      r0_rdata    <= r0_rdata_d;
      r1_rdata    <= r1_rdata_d;
      r0_rvalid   <= r0_rvalid_d;
      r0_err      <= r0_err_d;
      r1_done     <= r1_done_d;
      r1_err      <= r1_err_d;
    end
  end

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Scoreboard bench for flash_req_arbiter: randomized rounds against a
// service-order reference model with a behavioural LLC responder.
module tb_flash_req_arbiter;
  import flash_arb_pkg::*;

  localparam int P  = 5;
  localparam int TO = 64;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        r0_req, r0_gnt, r0_rvalid, r0_err;
  logic [23:0] r0_addr;
  logic [31:0] r0_rdata;
  logic        r1_req, r1_gnt, r1_done, r1_err;
  logic [1:0]  r1_op;
  logic [23:0] r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic        llc_start, llc_dir, llc_erase, llc_axisync;
  logic [23:0] llc_address;
  logic [31:0] llc_word, llc_rword;
  logic        llc_valid, llc_busy;

  flash_req_arbiter #(.PRESCALE(P), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rdata(r0_rdata),
    .r0_rvalid(r0_rvalid), .r0_err(r0_err),
    .r1_req(r1_req), .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_done(r1_done), .r1_err(r1_err),
    .llc_start(llc_start), .llc_dir(llc_dir), .llc_erase(llc_erase),
    .llc_address(llc_address), .llc_word(llc_word), .llc_axisync(llc_axisync),
    .llc_rword(llc_rword), .llc_valid(llc_valid), .llc_busy(llc_busy)
  );

  typedef struct {
    logic        who;
    logic [1:0]  op;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [31:0] rdata;
    int          lat;
    int          exp_lat;
    logic        err;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ndone = 0;
  int          gnt_cyc = 0;
  int          scnt = 0;
  logic        last_who = 1'b1;
  logic [31:0] m0 = '0;
  logic [31:0] m1 = '0;
  logic        rose = 1'b0;
  logic        prev_start = 1'b0;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  // Reference model: service order, poll points on multiples of P, abort after TO wait cycles
  task automatic push_txn(input logic who, input logic [1:0] op, input logic [23:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] rword);
    txn_t e;
    int   s;
    e.who = who; e.op = who ? op : 2'(OP_READ); e.addr = addr; e.wdata = wdata;
    e.rword = rword; e.lat = lat;
    if (e.op == OP_RSVD) begin
      e.exp_lat = 1; e.err = 1'b1;
    end else begin
      s = P;
      while (s < 1 + lat) s += P;
      if (s <= TO) begin
        e.exp_lat = s + 1; e.err = 1'b0;
        if (e.op == OP_READ) begin
          if (who) m1 = rword; else m0 = rword;
        end
      end else begin
        e.exp_lat = TO + 1; e.err = 1'b1;
      end
    end
    e.rdata = who ? m1 : m0;
    last_who = who;
    exp_q.push_back(e);
  endtask

  // Behavioural LLC: valid rises lat cycles after start and holds until start drops
  initial begin
    llc_valid = 1'b0;
    llc_rword = '0;
    forever begin
      @(posedge ACLK); #1;
      if (llc_start) scnt++; else scnt = 0;
      llc_valid = (scnt > 0) && (exp_q.size() > 0) && (scnt > exp_q[0].lat);
      llc_rword = (llc_start && exp_q.size() > 0) ? exp_q[0].rword : $urandom();
    end
  end

  // Monitor: grants, LLC command and completions against the scoreboard
  initial begin
    txn_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETn) begin
        if (llc_busy) check("busy_blocks_gnt", 64'(r0_gnt | r1_gnt), 64'd0);
        if (r0_gnt || r1_gnt) begin
          check("gnt_onehot", 64'(r0_gnt & r1_gnt), 64'd0);
          check("gnt_axisync", 64'(llc_axisync), 64'd1);
          if (exp_q.size() == 0) fail_now("gnt_unexpected");
          else check("gnt_who", 64'(r1_gnt), 64'(exp_q[0].who));
          gnt_cyc = cyc;
          rose = 1'b0;
        end
        if (llc_start && !prev_start) begin
          rose = 1'b1;
          if (exp_q.size() == 0) fail_now("start_unexpected");
          else begin
            e = exp_q[0];
            check("start_lat", 64'(cyc - gnt_cyc), 64'd1);
            check("llc_dir", 64'(llc_dir), 64'(e.op == OP_WRITE));
            check("llc_erase", 64'(llc_erase), 64'(e.op == OP_ERASE));
            if (e.op == OP_WRITE) check("llc_word", 64'(llc_word), 64'(e.wdata));
          end
        end
        if (llc_start && exp_q.size() > 0) check("llc_addr_hold", 64'(llc_address), 64'(exp_q[0].addr));
        prev_start = llc_start;
        if (r0_err || r1_err)
          check("err_needs_pulse", 64'({r0_err & ~r0_rvalid, r1_err & ~r1_done}), 64'd0);
        if (r0_rvalid || r1_done) begin
          check("done_onehot", 64'(r0_rvalid & r1_done), 64'd0);
          if (exp_q.size() == 0) fail_now("done_unexpected");
          else begin
            e = exp_q.pop_front();
            check("done_who", 64'(r1_done), 64'(e.who));
            check("done_lat", 64'(cyc - gnt_cyc), 64'(e.exp_lat));
            check("done_err", 64'(r1_done ? r1_err : r0_err), 64'(e.err));
            check("done_rdata", 64'(r1_done ? r1_rdata : r0_rdata), 64'(e.rdata));
            check("done_start_low", 64'({llc_start, llc_address != 24'd0}), 64'd0);
            if (e.op == OP_RSVD) check("rsvd_no_start", 64'(rose), 64'd0);
          end
          ndone++;
        end
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  // One round: push expectations in service order, raise requests, drop each on grant
  task automatic do_round(input logic [1:0] mask, input logic [23:0] a0, input logic [1:0] op1,
                          input logic [23:0] a1, input logic [31:0] wd1, input int lat0,
                          input int lat1, input logic [31:0] rw0, input logic [31:0] rw1,
                          input int busy);
    int   target, bc;
    logic g0, g1, ghost, ok;
    target = ndone + int'(mask[0]) + int'(mask[1]);
    if (mask == 2'b11) begin
      if (last_who) begin
        push_txn(1'b0, 2'(OP_READ), a0, '0, lat0, rw0);
        push_txn(1'b1, op1, a1, wd1, lat1, rw1);
      end else begin
        push_txn(1'b1, op1, a1, wd1, lat1, rw1);
        push_txn(1'b0, 2'(OP_READ), a0, '0, lat0, rw0);
      end
    end else if (mask[0]) begin
      push_txn(1'b0, 2'(OP_READ), a0, '0, lat0, rw0);
    end else begin
      push_txn(1'b1, op1, a1, wd1, lat1, rw1);
    end
    bc = busy;
    ghost = (bc > 0) && !mask[0];
    llc_busy = (bc > 0);
    r0_addr = a0; r1_op = op1; r1_addr = a1; r1_wdata = wd1;
    r0_req = mask[0] | ghost;
    r1_req = mask[1];
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge ACLK);
      g0 = r0_gnt; g1 = r1_gnt;
      @(posedge ACLK); #1;
      if (g0) r0_req = 1'b0;
      if (g1) r1_req = 1'b0;
      if (bc > 0) begin
        bc--;
        if (bc == 0) begin
          llc_busy = 1'b0;
          if (ghost) r0_req = 1'b0;
        end
      end
      if (ndone >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("round_timeout");
    r0_req = 1'b0; r1_req = 1'b0; llc_busy = 1'b0;
  endtask

  initial begin
    logic [1:0] mask, op1;
    int         l0, l1, bz;
    logic       seen;
    r0_req = 0; r0_addr = '0; r1_req = 0; r1_op = '0; r1_addr = '0; r1_wdata = '0; llc_busy = 0;

    repeat (3) @(negedge ACLK);
    check("rst_axisync", 64'(llc_axisync), 64'd1);
    check("rst_start", 64'({llc_start, llc_dir, llc_erase}), 64'd0);
    check("rst_rdata", 64'({r0_rdata, r1_rdata}), 64'd0);
    check("rst_pulses", 64'({r0_rvalid, r0_err, r1_done, r1_err}), 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Tie from reset: r0 first, then r1 write; next tie again r0
    do_round(2'b11, 24'h000300, 2'(OP_WRITE), 24'h000200, 32'h12345678, 6, 3, 32'hCAFEF00D, 32'h0, 0);
    do_round(2'b11, 24'h000304, 2'(OP_READ), 24'h000208, 32'h0, 0, 12, 32'h01020304, 32'hA5A5A5A5, 0);
    do_round(2'b01, 24'h000100, 2'(OP_READ), 24'h0, 32'h0, 2, 0, 32'hDEADBEEF, 32'h0, 0);
    do_round(2'b10, 24'h0, 2'(OP_ERASE), 24'h010000, 32'h0, 0, 9, 32'h0, 32'h77777777, 0);
    do_round(2'b10, 24'h0, 2'(OP_READ), 24'h020000, 32'h0, 0, 1000, 32'h0, 32'h55555555, 0);
    do_round(2'b10, 24'h0, 2'(OP_RSVD), 24'h030000, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    do_round(2'b10, 24'h0, 2'(OP_READ), 24'h000040, 32'h0, 0, 58, 32'h0, 32'h13579BDF, 3);
    do_round(2'b10, 24'h0, 2'(OP_READ), 24'h000044, 32'h0, 0, 60, 32'h0, 32'h2468ACE0, 0);

    for (int r = 0; r < 40; r++) begin
      mask = 2'($urandom_range(1, 3));
      op1  = 2'($urandom_range(0, 3));
      l0 = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 62));
      l1 = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 62));
      bz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_round(mask, 24'($urandom()), op1, 24'($urandom()), $urandom(), l0, l1,
               $urandom(), $urandom(), bz);
    end

    // Reset during WAIT: start falls at once, no completion, then a clean read
    push_txn(1'b0, 2'(OP_READ), 24'h000400, '0, 1000, 32'h99999999);
    r0_addr = 24'h000400;
    r0_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      seen = r0_gnt;
      @(posedge ACLK); #1;
    end
    r0_req = 1'b0;
    if (!seen) fail_now("rst_test_no_gnt");
    repeat (8) @(posedge ACLK);
    #2;
    check("pre_rst_start", 64'(llc_start), 64'd1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_start", 64'(llc_start), 64'd0);
    check("mid_rst_axisync", 64'(llc_axisync), 64'd1);
    exp_q.delete();
    last_who = 1'b1; m0 = '0; m1 = '0;
    repeat (2) begin
      @(negedge ACLK);
      check("mid_rst_no_pulse", 64'({r0_rvalid, r1_done}), 64'd0);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    do_round(2'b01, 24'h000500, 2'(OP_READ), 24'h0, 32'h0, 7, 0, 32'h0BADF00D, 32'h0, 0);

    repeat (4) @(posedge ACLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
